scan_wrapper_lanes: RTL

- Parametrised synchronous successor to the single-bit TinyTapeout scan wrapper.
- Generalises it in three ways:
  - configurable user input width and user output width;
  - LANES parallel serial lanes per clock;
  - edge-detected latch into a registered user input bus.
- Sits between the scan chain (previous/next tile) and one user design.
- Passes scan control down the chain one cycle delayed.

---
 rtl/scan_wrapper_lanes.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/scan_wrapper_lanes.sv
// -----------------------------------------------------------------------------
// scan_wrapper_lanes
//
// Purpose:
//   Parametrised scan-chain wrapper that sits between a scan chain and one
//   user design. Scan data is shifted LANES bits per clock through a chain
//   register C of IN_W+OUT_W bits:
//     C[IN_W-1:0]   input section: the value that will be latched into io_in
//     C[L-1:IN_W]   output section: loaded from io_out on a capture cycle
//   A rising edge on latch_enable_in copies the input section into the
//   registered user input bus io_in. Scan control signals are passed down
//   the chain with one cycle of delay.
//
// Optional feature (macro SCAN_PARITY_EN):
//   When defined, C[IN_W-1] is an even-parity bit over C[IN_W-1:0]. A latch
//   is only accepted when parity is good; a bad latch leaves io_in and
//   io_in_valid unchanged and sets a sticky parity error. When undefined,
//   every latch edge is accepted and parity_err_out is tied low.
//
// Ports:
//   clk_in            in   1      clock, rising edge
//   reset_in          in   1      synchronous active-high reset
//   data_in           in   LANES  serial scan data from upstream
//   latch_enable_in   in   1      latch request, rising edge acts
//   scan_select_in    in   1      1 = capture io_out, 0 = shift
//   io_out            in   OUT_W  outputs of the user design
//   data_out          out  LANES  serial scan data to downstream (top of C)
//   latch_enable_out  out  1      latch_enable_in delayed one cycle
//   scan_select_out   out  1      scan_select_in delayed one cycle
//   io_in             out  IN_W   registered inputs to the user design
//   io_in_valid       out  1      set once a latch has been accepted
//   parity_err_out    out  1      sticky parity error
//
// Handshake: there is no valid/ready flow control. Each cycle the chain
// either shifts or captures according to scan_select_in; latching is an
// orthogonal event triggered by the rising edge of latch_enable_in.
// -----------------------------------------------------------------------------
module scan_wrapper_lanes #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int LANES = 1
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [LANES-1:0] data_in,
    input  logic             latch_enable_in,
    input  logic             scan_select_in,
    input  logic [OUT_W-1:0] io_out,
    output logic [LANES-1:0] data_out,
    output logic             latch_enable_out,
    output logic             scan_select_out,
    output logic [IN_W-1:0]  io_in,
    output logic             io_in_valid,
    output logic             parity_err_out
);

    localparam int L = IN_W + OUT_W;

    // Both sections must hold a whole number of lane-words so that a full
    // pass lines up with the section boundary.
    generate
        if ((LANES < 1) || ((IN_W % LANES) != 0) || ((OUT_W % LANES) != 0)) begin : g_bad_cfg
            $error("scan_wrapper_lanes: IN_W and OUT_W must be divisible by LANES");
        end
    endgenerate

    logic [L-1:0]    r_chain;
    logic            r_le_prev;
    logic [IN_W-1:0] r_io_in;
    logic            r_io_in_valid;
    logic            r_latch_enable_out;
    logic            r_scan_select_out;

    logic            w_latch_edge;
    logic [IN_W-1:0] w_in_sec;

    always_comb begin
        w_latch_edge = latch_enable_in & ~r_le_prev;
        // Pre-update input section: a latch in the same cycle as a shift
        // must see the value before the shift.
        w_in_sec     = r_chain[IN_W-1:0];
    end

`ifdef SCAN_PARITY_EN
    logic r_parity_err;
    logic w_parity_ok;

    always_comb begin
        w_parity_ok = ~(^w_in_sec);
    end
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_chain            <= '0;
            r_le_prev          <= 1'b0;
            r_io_in            <= '0;
            r_io_in_valid      <= 1'b0;
            r_latch_enable_out <= 1'b0;
            r_scan_select_out  <= 1'b0;
`ifdef SCAN_PARITY_EN
            r_parity_err       <= 1'b0;
`endif
        end else begin
            r_le_prev          <= latch_enable_in;
            r_latch_enable_out <= latch_enable_in;
            r_scan_select_out  <= scan_select_in;

            if (scan_select_in) begin
                // Capture: only the output section is loaded.
                r_chain[L-1:IN_W] <= io_out;
            end else begin
                // Shift: data_in[LANES-1] lands in C[LANES-1].
                r_chain <= {r_chain[L-LANES-1:0], data_in};
            end

            if (w_latch_edge) begin
`ifdef SCAN_PARITY_EN
                if (w_parity_ok) begin
                    r_io_in       <= {1'b0, w_in_sec[IN_W-2:0]};
                    r_io_in_valid <= 1'b1;
                end else begin
                    r_parity_err  <= 1'b1;
                end
`else
                r_io_in       <= w_in_sec;
                r_io_in_valid <= 1'b1;
`endif
            end
        end
    end

    assign data_out         = r_chain[L-1:L-LANES];
    assign latch_enable_out = r_latch_enable_out;
    assign scan_select_out  = r_scan_select_out;
    assign io_in            = r_io_in;
    assign io_in_valid      = r_io_in_valid;
`ifdef SCAN_PARITY_EN
    assign parity_err_out   = r_parity_err;
`else
    assign parity_err_out   = 1'b0;
`endif

endmodule
